ws2811_serializer: RTL and testbench
====================================

Name: ws2811_serializer

Overview:
- Produces the single-wire WS2811/WS2812B LED-strip waveform `io_ws2811_dout`; the pin mux routes it to GPIOB[12] when MUX_WS2811 is selected.
- Takes 24-bit GRB pixels over a valid/ready stream from the MuraxArduino bus-side register block.
- A one-entry holding buffer lets back-to-back pixels stream with no inter-pixel gap.
- A pixel flagged last is followed by the strip latch (reset) low period.

Parameters:
- T0H, 20, high-phase length of a 0 bit in clock cycles (0.4 us at 50 MHz).
- T1H, 40, high-phase length of a 1 bit in clock cycles.
- TBIT, 63, total bit period in clock cycles; required 0 < T0H < T1H < TBIT.
- RESET_CYCLES, 3000, latch low period in clock cycles after a last pixel (60 us at 50 MHz).

Ports:
- io_mainClk  in  1  system clock.
- io_asyncReset_n  in  1  reset, asynchronous, active-low.
- io_pixel_valid  in  1  pixel offered.
- io_pixel_ready  out  1  holding buffer empty; transfer when valid & ready at a rising edge.
- io_pixel_data  in  24  GRB pixel, bit 23 transmitted first.
- io_pixel_last  in  1  pixel ends a frame; the latch period follows it.
- io_ws2811_dout  out  1  registered strip data output.
- io_busy  out  1  high in any state other than IDLE, or when the holding buffer is full.
- io_underrun  out  1  one-cycle pulse when a non-last pixel completes with the holding buffer empty.

Behaviour:
- Reset values:
  - dout=0, busy=0, underrun=0, ready=1.
  - Holding buffer empty; state IDLE; all counters 0.
  - Assertion mid-frame forces dout low asynchronously and discards shift and hold contents.
- Holding buffer:
  - Registers {data,last} on handshake.
  - ready = !holdValid (registered, no combinational path from valid).
  - The buffer empties on the edge where its contents move to the shift register.
  - A new handshake is possible the following cycle.
- States: IDLE, HIGH, LOW, LATCH. Registers: 24-bit shift register, 5-bit bit index, cycle counter of width clog2(max(TBIT,RESET_CYCLES)+1).
- IDLE:
  - dout=0.
  - If holdValid: load the shift register, bitIdx=23, counter=0, go to HIGH.
  - Latency: handshake at edge E0 -> dout high after edge E2.
- HIGH:
  - dout=1.
  - Stays for Th cycles, where Th = T1H if the current bit is 1, else T0H.
  - Then go to LOW with the counter continuing.
- LOW:
  - dout=0 until the counter reaches TBIT; each bit occupies exactly TBIT cycles.
  - End of bit with bitIdx>0: shift left, decrement bitIdx, go to HIGH.
  - End of bit 0 (pixel done), first matching rule applies:
    1. Current pixel last -> LATCH, counter=0.
    2. holdValid -> load the next pixel, go to HIGH the next cycle, with no gap beyond TBIT framing.
    3. Otherwise -> IDLE and pulse underrun for 1 cycle; the strip may latch early, and software is responsible for this.
- LATCH:
  - dout=0 for RESET_CYCLES cycles, then IDLE. The holding buffer may accept during LATCH.
  - The pixel stored during LATCH starts from IDLE on the cycle after LATCH ends.
- Simultaneous events:
  - A handshake on the same edge the buffer drains is impossible, because ready was 0.
  - A handshake on the final LOW edge with the buffer empty is not seen in time: underrun still pulses, then IDLE starts the pixel.
- Input changes while ready=0 are ignored.

Decomposition:
- Shared package ws2811_pkg holds:
  - the state enum (IDLE/HIGH/LOW/LATCH);
  - the default timing constants for a 50 MHz main clock;
  - the pixel width constant (24).
- Single module; the timer is a plain counter, and no sub-module is warranted.

Test Plan (bench uses T0H=2, T1H=4, TBIT=8, RESET_CYCLES=20):
- Reset then idle:
  - Stimulus: hold io_asyncReset_n low 3 cycles, then release, with no valid.
  - Required: dout=0, ready=1, busy=0 throughout 50 cycles.
- Single pixel 0xA50000 with last=1:
  - dout high 2 cycles after the handshake edge.
  - Bit pattern 1,0,1,0,0,1,0,1,0x16: high widths 4,2,4,2,2,4,2,4,2..., each period 8 cycles, total 192 cycles.
  - Then 20 low cycles in LATCH, then IDLE.
- Back-to-back 0xFFFFFF, 0x000000(last), second offered while the first is shifting:
  - ready drops after the first handshake and reasserts when the hold drains.
  - No gap between pixels: 384 contiguous cycles, then the latch.
- Underrun on 0x800000 with last=0 and no follow-up:
  - After 192 cycles, underrun pulses exactly 1 cycle and the state returns to IDLE with dout=0.
- Reset asserted mid-pixel during a HIGH phase:
  - dout falls without waiting for a clock edge.
  - After release: ready=1, and no residual bits are emitted.
- Pixel offered during LATCH:
  - Accepted (ready=1); transmission starts 2 cycles after LATCH ends.
  - Latch low length is still exactly 20 cycles.

Source files
------------

// File: rtl/ws2811_pkg.sv
// Shared types and default timing for the WS2811/WS2812B strip serializer.
// Default timing assumes a 50 MHz main clock.
package ws2811_pkg;

    localparam int PIXEL_W          = 24;
    localparam int DEF_T0H          = 20;
    localparam int DEF_T1H          = 40;
    localparam int DEF_TBIT         = 63;
    localparam int DEF_RESET_CYCLES = 3000;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } state_e;

endpackage

// File: rtl/ws2811_serializer.sv
// Serializes 24-bit GRB pixels onto the single-wire WS2811 data line, with a
// one-entry holding buffer so consecutive pixels stream without a gap.
module ws2811_serializer
    import ws2811_pkg::*;
#(
    parameter int T0H          = DEF_T0H,
    parameter int T1H          = DEF_T1H,
    parameter int TBIT         = DEF_TBIT,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic               io_mainClk,
    input  logic               io_asyncReset_n,
    input  logic               io_pixel_valid,
    output logic               io_pixel_ready,
    input  logic [PIXEL_W-1:0] io_pixel_data,
    input  logic               io_pixel_last,
    output logic               io_ws2811_dout,
    output logic               io_busy,
    output logic               io_underrun
);

    localparam int CNT_MAX = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Counter values on the last cycle of each phase.
    localparam logic [CW-1:0] T0H_END  = CW'(T0H - 1);
    localparam logic [CW-1:0] T1H_END  = CW'(T1H - 1);
    localparam logic [CW-1:0] TBIT_END = CW'(TBIT - 1);
    localparam logic [CW-1:0] RST_END  = CW'(RESET_CYCLES - 1);

    state_e             state_q, state_d;
    logic [PIXEL_W-1:0] shift_q, shift_d;
    logic [PIXEL_W-1:0] hold_data_q, hold_data_d;
    logic               hold_valid_q, hold_valid_d;
    logic               hold_last_q, hold_last_d;
    logic               cur_last_q, cur_last_d;
    logic [4:0]         bit_idx_q, bit_idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               dout_q, dout_d;
    logic               underrun_q, underrun_d;
    logic               load;
    logic               accept;
    logic [CW-1:0]      th_end;

    assign accept = io_pixel_valid && !hold_valid_q;
    assign th_end = shift_q[PIXEL_W-1] ? T1H_END : T0H_END;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        cnt_d        = cnt_q;
        cur_last_d   = cur_last_q;
        underrun_d   = 1'b0;
        load         = 1'b0;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;

        case (state_q)
            IDLE: begin
                if (hold_valid_q) load = 1'b1;
            end
            HIGH: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == th_end) state_d = LOW;
            end
            LOW: begin
                if (cnt_q != TBIT_END) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (bit_idx_q != 5'd0) begin
                    shift_d   = shift_q << 1;
                    bit_idx_d = bit_idx_q - 5'd1;
                    cnt_d     = '0;
                    state_d   = HIGH;
                end else if (cur_last_q) begin
                    cnt_d   = '0;
                    state_d = LATCH;
                end else if (hold_valid_q) begin
                    load = 1'b1;
                end else begin
                    // Strip starved mid-frame; it may latch early.
                    cnt_d      = '0;
                    underrun_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            LATCH: begin
                if (cnt_q == RST_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d      = hold_data_q;
            cur_last_d   = hold_last_q;
            bit_idx_d    = 5'(PIXEL_W - 1);
            cnt_d        = '0;
            state_d      = HIGH;
            hold_valid_d = 1'b0;
        end

        // load needs a full buffer and accept an empty one, so they never collide.
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = io_pixel_data;
            hold_last_d  = io_pixel_last;
        end

        dout_d = (state_q == HIGH);
    end

    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            cur_last_q   <= 1'b0;
            bit_idx_q    <= '0;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            hold_last_q  <= hold_last_d;
            cur_last_q   <= cur_last_d;
            bit_idx_q    <= bit_idx_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            underrun_q   <= underrun_d;
        end
    end

    assign io_pixel_ready = !hold_valid_q;
    assign io_busy        = (state_q != IDLE) || hold_valid_q;
    assign io_ws2811_dout = dout_q;
    assign io_underrun    = underrun_q;

endmodule

// File: tb/tb_ws2811_serializer.sv
// Scoreboard bench: stimulus queues the expected bit stream, a monitor decodes
// the dout waveform (high widths and rise-to-rise spacing) and checks it.
module tb_ws2811_serializer;

    localparam int T0H          = 2;
    localparam int T1H          = 4;
    localparam int TBIT         = 8;
    localparam int RESET_CYCLES = 20;

    typedef struct {
        logic val;
        int   gap;   // required spacing from the previous rise, 0 = unconstrained
    } bit_t;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [23:0] data;
    logic        last;
    logic        dout;
    logic        busy;
    logic        underrun;

    int   checks;
    int   errors;
    int   cyc;
    int   urun_cycles;
    bit_t sb[$];

    ws2811_serializer #(
        .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .io_mainClk      (clk),
        .io_asyncReset_n (rst_n),
        .io_pixel_valid  (valid),
        .io_pixel_ready  (ready),
        .io_pixel_data   (data),
        .io_pixel_last   (last),
        .io_ws2811_dout  (dout),
        .io_busy         (busy),
        .io_underrun     (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pixel(input logic [23:0] d, input int gap_first);
        for (int i = 23; i >= 0; i--) begin
            bit_t b;
            b.val = d[i];
            b.gap = (i == 23) ? gap_first : TBIT;
            sb.push_back(b);
        end
    endtask

    task automatic send(input logic [23:0] d, input logic l, output int hs);
        int n;
        n = 0;
        @(negedge clk);
        valid = 1'b1;
        data  = d;
        last  = l;
        while (!ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("send_timeout", 0, 1);
        @(negedge clk);
        hs    = cyc;
        valid = 1'b0;
        data  = '0;
        last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || dout) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(n < 5000), 1);
        repeat (5) @(negedge clk);
    endtask

    // Waveform monitor / scoreboard checker.
    logic in_high;
    logic have_prev;
    logic cur_valid;
    int   rise_t;
    int   prev_rise;
    bit_t cur;
    initial begin
        in_high     = 1'b0;
        have_prev   = 1'b0;
        cur_valid   = 1'b0;
        urun_cycles = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            in_high   = 1'b0;
            have_prev = 1'b0;
            cur_valid = 1'b0;
            sb.delete();
        end else begin
            if (underrun) urun_cycles++;
            if (dout && !in_high) begin
                in_high = 1'b1;
                rise_t  = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                    cur_valid = 1'b0;
                end else begin
                    cur       = sb.pop_front();
                    cur_valid = 1'b1;
                    if (cur.gap != 0 && have_prev)
                        chk("bit_spacing", cyc - prev_rise, cur.gap);
                end
                prev_rise = cyc;
                have_prev = 1'b1;
            end else if (!dout && in_high) begin
                in_high = 1'b0;
                if (cur_valid)
                    chk(cur.val ? "high_width_1" : "high_width_0", cyc - rise_t,
                        cur.val ? T1H : T0H);
                cur_valid = 1'b0;
            end
        end
    end

    initial begin
        int          h, h2, n;
        logic [23:0] d;
        logic        l, prev_last, first;
        int          g;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        valid  = 1'b0;
        data   = '0;
        last   = 1'b0;

        // Reset, then idle with no traffic.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout", int'(dout), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_underrun", int'(underrun), 0);
        rst_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            chk("idle_dout", int'(dout), 0);
            chk("idle_ready", int'(ready), 1);
            chk("idle_busy", int'(busy), 0);
        end

        // Single last pixel: 2-edge latency, 24 bits, then latch.
        push_pixel(24'hA50000, 0);
        send(24'hA50000, 1'b1, h);
        chk("lat_e0", int'(dout), 0);
        chk("hold_full_ready", int'(ready), 0);
        @(negedge clk);
        chk("lat_e1", int'(dout), 0);
        @(negedge clk);
        chk("lat_e2", int'(dout), 1);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        // One IDLE pickup edge, 24 bit periods, then the latch.
        chk("frame_len", cyc - h, 1 + 24 * TBIT + RESET_CYCLES);
        wait_idle();

        // Back-to-back pixels streamed through the holding buffer.
        push_pixel(24'hFFFFFF, 0);
        send(24'hFFFFFF, 1'b0, h);
        chk("b2b_ready_low", int'(ready), 0);
        @(negedge clk);
        chk("b2b_ready_drain", int'(ready), 1);
        push_pixel(24'h000000, TBIT);
        send(24'h000000, 1'b1, h2);
        chk("b2b_ready_low2", int'(ready), 0);
        chk("b2b_busy", int'(busy), 1);
        n = 0;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_hold_drain", cyc - h, 1 + 24 * TBIT);
        wait_idle();

        // Underrun: non-last pixel with nothing following.
        push_pixel(24'h800000, 0);
        send(24'h800000, 1'b0, h);
        n = 0;
        while (!underrun && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("urun_time", cyc - h, 1 + 24 * TBIT);
        chk("urun_busy", int'(busy), 0);
        chk("urun_dout", int'(dout), 0);
        @(negedge clk);
        chk("urun_width", int'(underrun), 0);
        wait_idle();

        // Reset during the HIGH phase of bit 3.
        push_pixel(24'hFFFFFF, 0);
        send(24'hFFFFFF, 1'b1, h);
        repeat (26) @(negedge clk);
        chk("rst_pre_high", int'(dout), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_dout", int'(dout), 0);
        chk("rst_async_ready", int'(ready), 1);
        chk("rst_async_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_ready", int'(ready), 1);
        repeat (300) @(negedge clk);
        chk("rst_no_residual_busy", int'(busy), 0);

        // Randomized stream; every pixel offered as soon as the buffer frees.
        prev_last = 1'b0;
        first     = 1'b1;
        for (int p = 0; p < 6; p++) begin
            d = 24'($urandom);
            l = (p == 5) || ($urandom_range(0, 2) == 0);
            g = first ? 0 : (prev_last ? TBIT + RESET_CYCLES + 1 : TBIT);
            push_pixel(d, g);
            send(d, l, h);
            first     = 1'b0;
            prev_last = l;
        end
        wait_idle();

        // Pixel offered while the latch is running.
        push_pixel(24'h5A5A5A, 0);
        send(24'h5A5A5A, 1'b1, h);
        repeat (200) @(negedge clk);
        chk("latch_busy", int'(busy), 1);
        chk("latch_ready", int'(ready), 1);
        chk("latch_dout", int'(dout), 0);
        push_pixel(24'h123456, TBIT + RESET_CYCLES + 1);
        send(24'h123456, 1'b1, h2);
        chk("latch_accept_ready", int'(ready), 0);
        wait_idle();

        chk("sb_empty", sb.size(), 0);
        chk("underrun_cycles", urun_cycles, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
